// File: rtl/cla_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: FSM state encoding and slice width.
package cla_serial_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/cla_serial_adder_cla4.sv
// 4-bit carry-lookahead slice with group propagate/generate outputs.
module cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout,
    output logic       p_grp,
    output logic       g_grp
);

    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;

    always_comb begin
        p    = a ^ b;
        g    = a & b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        s     = p ^ c[3:0];
        cout  = c[4];
        p_grp = &p;
        g_grp = c[4] & ~(&p) | (g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]));
    end

endmodule

// File: rtl/cla_serial_adder.sv
// Nibble-serial adder/subtractor: one cla4 slice walks the operands LSB nibble first,
// with a valid/ready request side and a result held until the consumer takes it.
module cla_serial_adder
    import cla_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int IDX_W = $clog2(NIB);

    state_e                           state_q, state_d;
    logic [IDX_W-1:0]                 idx_q, idx_d;
    logic                             carry_q, carry_d;
    logic [NIB-1:0][NIBBLE_W-1:0]     a_q, a_d;
    logic [NIB-1:0][NIBBLE_W-1:0]     b_q, b_d;
    logic [NIB-1:0][NIBBLE_W-1:0]     sum_q, sum_d;
    logic                             in_ready_q, in_ready_d;
    logic                             out_valid_q, out_valid_d;

    logic [NIBBLE_W-1:0] slice_sum;
    logic                slice_cout;

    // Group P/G are not needed: the carry is chained through carry_q one nibble per clock.
    cla4 u_slice (
        .a     (a_q[idx_q]),
        .b     (b_q[idx_q]),
        .cin   (carry_q),
        .s     (slice_sum),
        .cout  (slice_cout),
        .p_grp (),
        .g_grp ()
    );

    always_comb begin
        // NOTE: every variable gets a default first so no path through the case infers a latch.
        state_d     = state_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d        = a;
                    b_d        = b ^ {WIDTH{sub}};
                    carry_d    = sub;
                    idx_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                sum_d[idx_q] = slice_sum;
                carry_d      = slice_cout;
                if (idx_q == IDX_W'(NIB - 1)) begin
                    idx_d       = '0;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    // NOTE: operand registers are reset too, so the flag outputs derived from them read 0 in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking here so every flop samples the pre-edge values from always_comb.
            state_q     <= state_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = carry_q;
    // b_q already holds the inverted-if-subtract operand, so this is the true signed overflow.
    assign ovf       = (a_q[NIB-1][NIBBLE_W-1] == b_q[NIB-1][NIBBLE_W-1])
                     & (sum_q[NIB-1][NIBBLE_W-1] != a_q[NIB-1][NIBBLE_W-1]);
    assign zero      = out_valid_q & (sum_q == '0);

endmodule

// File: tb/tb_cla_serial_adder.sv
// Directed and random checks of cla_serial_adder at WIDTH 8, 16 and 32.
module tb_cla_serial_adder;

    logic clk;
    logic rst_n;

    logic        in_valid8, in_ready8, out_valid8, out_ready8, sub8, cout8, ovf8, zero8;
    logic [7:0]  a8, b8, sum8;
    logic        in_valid16, in_ready16, out_valid16, out_ready16, sub16, cout16, ovf16, zero16;
    logic [15:0] a16, b16, sum16;
    logic        in_valid32, in_ready32, out_valid32, out_ready32, sub32, cout32, ovf32, zero32;
    logic [31:0] a32, b32, sum32;

    int n_vec  = 0;
    int n_miss = 0;

    cla_serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .sub(sub8), .out_valid(out_valid8), .out_ready(out_ready8),
        .sum(sum8), .cout(cout8), .ovf(ovf8), .zero(zero8)
    );

    cla_serial_adder #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .sub(sub16), .out_valid(out_valid16), .out_ready(out_ready16),
        .sum(sum16), .cout(cout16), .ovf(ovf16), .zero(zero16)
    );

    cla_serial_adder #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
        .a(a32), .b(b32), .sub(sub32), .out_valid(out_valid32), .out_ready(out_ready32),
        .sum(sum32), .cout(cout32), .ovf(ovf32), .zero(zero32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] get_sum(input int w);
        case (w)
            8:       return {24'h0, sum8};
            16:      return {16'h0, sum16};
            default: return sum32;
        endcase
    endfunction

    function automatic logic [3:0] get_flags(input int w);
        // {in_ready, out_valid, cout, ovf} packed with zero kept separate
        case (w)
            8:       return {in_ready8, out_valid8, cout8, ovf8};
            16:      return {in_ready16, out_valid16, cout16, ovf16};
            default: return {in_ready32, out_valid32, cout32, ovf32};
        endcase
    endfunction

    function automatic logic get_zero(input int w);
        case (w)
            8:       return zero8;
            16:      return zero16;
            default: return zero32;
        endcase
    endfunction

    task automatic drive(input int w, input logic v, input logic [31:0] av, input logic [31:0] bv, input logic sv);
        case (w)
            8:       begin in_valid8  = v; a8  = av[7:0];  b8  = bv[7:0];  sub8  = sv; end
            16:      begin in_valid16 = v; a16 = av[15:0]; b16 = bv[15:0]; sub16 = sv; end
            default: begin in_valid32 = v; a32 = av;       b32 = bv;       sub32 = sv; end
        endcase
    endtask

    task automatic set_ordy(input int w, input logic v);
        case (w)
            8:       out_ready8  = v;
            16:      out_ready16 = v;
            default: out_ready32 = v;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full request/response transaction with latency and handshake checks.
    task automatic run_op(input int w, input logic [31:0] av, input logic [31:0] bv, input logic sv,
                          input logic [31:0] es, input logic ec, input logic eo, input logic ez,
                          input string name);
        int t;
        int lat;
        t = 0;
        while (!get_flags(w)[3] && t < 50) begin
            tick();
            t++;
        end
        check({name, " in_ready before"}, {31'h0, get_flags(w)[3]}, 32'd1);
        drive(w, 1'b1, av, bv, sv);
        tick();
        drive(w, 1'b0, 32'h0, 32'h0, 1'b0);
        lat = 0;
        while (!get_flags(w)[2] && lat < 40) begin
            tick();
            lat++;
        end
        check({name, " latency"}, lat, w / 4);
        check({name, " sum"}, get_sum(w), es);
        check({name, " cout"}, {31'h0, get_flags(w)[1]}, {31'h0, ec});
        check({name, " ovf"}, {31'h0, get_flags(w)[0]}, {31'h0, eo});
        check({name, " zero"}, {31'h0, get_zero(w)}, {31'h0, ez});
        set_ordy(w, 1'b1);
        tick();
        set_ordy(w, 1'b0);
        check({name, " in_ready after"}, {31'h0, get_flags(w)[3]}, 32'd1);
        check({name, " out_valid after"}, {31'h0, get_flags(w)[2]}, 32'd0);
    endtask

    initial begin
        int t;
        logic [31:0] mask, av, bv, bp, es;
        logic [32:0] full;
        logic        sv, ec, eo;

        vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};

        rst_n = 1'b0;
        drive(8, 1'b0, 32'h0, 32'h0, 1'b0);
        drive(16, 1'b0, 32'h0, 32'h0, 1'b0);
        drive(32, 1'b0, 32'h0, 32'h0, 1'b0);
        set_ordy(8, 1'b0);
        set_ordy(16, 1'b0);
        set_ordy(32, 1'b0);
        #1;
        check("reset out_valid", {31'h0, out_valid16}, 32'd0);
        check("reset sum", {16'h0, sum16}, 32'h0);
        check("reset cout/ovf/zero", {29'h0, cout16, ovf16, zero16}, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("post-reset in_ready", {31'h0, in_ready16}, 32'd1);

        for (int i = 0; i < 7; i++) begin
            run_op(16, {16'h0, vecs[i].a}, {16'h0, vecs[i].b}, vecs[i].sub, {16'h0, vecs[i].sum},
                   vecs[i].cout, vecs[i].ovf, vecs[i].zero, $sformatf("vec%0d", i));
        end

        // Backpressure: result held 10 clocks while a second request is presented.
        drive(16, 1'b1, 32'h1111, 32'h2222, 1'b0);
        tick();
        drive(16, 1'b1, 32'hFFFF, 32'hFFFF, 1'b1);
        t = 0;
        while (!out_valid16 && t < 40) begin
            tick();
            t++;
        end
        check("bp latency", t, 4);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("bp hold%0d sum", i), {16'h0, sum16}, 32'h3333);
            check($sformatf("bp hold%0d out_valid", i), {31'h0, out_valid16}, 32'd1);
            check($sformatf("bp hold%0d in_ready", i), {31'h0, in_ready16}, 32'd0);
            tick();
        end
        drive(16, 1'b0, 32'h0, 32'h0, 1'b0);
        set_ordy(16, 1'b1);
        tick();
        set_ordy(16, 1'b0);
        check("bp in_ready next clk", {31'h0, in_ready16}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("bp no second accept %0d", i), {31'h0, out_valid16}, 32'd0);
            tick();
        end

        // Reset pulsed while the slice is on nibble 2.
        drive(16, 1'b1, 32'hAAAA, 32'h5555, 1'b0);
        tick();
        drive(16, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst out_valid", {31'h0, out_valid16}, 32'd0);
        check("midrst sum", {16'h0, sum16}, 32'h0);
        check("midrst zero", {31'h0, zero16}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("midrst in_ready", {31'h0, in_ready16}, 32'd1);
        check("midrst out_valid after", {31'h0, out_valid16}, 32'd0);
        run_op(16, 32'h1, 32'h1, 1'b0, 32'h2, 1'b0, 1'b0, 1'b0, "after midrst");

        // Random operands against a plain arithmetic reference.
        for (int wi = 0; wi < 3; wi++) begin
            int w;
            w = (wi == 0) ? 8 : (wi == 1) ? 16 : 32;
            mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
            for (int k = 0; k < 8; k++) begin
                av   = $urandom & mask;
                bv   = $urandom & mask;
                sv   = 1'($urandom_range(0, 1));
                bp   = (bv ^ {32{sv}}) & mask;
                full = {1'b0, av} + {1'b0, bp} + {32'h0, sv};
                es   = full[31:0] & mask;
                ec   = full[w];
                eo   = (av[w-1] == bp[w-1]) && (es[w-1] != av[w-1]);
                run_op(w, av, bv, sv, es, ec, eo, (es == 32'h0), $sformatf("rand w%0d #%0d", w, k));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
